subtrator_serial: RTL and testbench
===================================

// Module: subtrator_serial
//
// PURPOSE
//   Bit-serial WIDTH-bit subtractor: computes a - b one bit per clock, LSB first,
//   using a single full-subtractor cell and a registered borrow.
//   Companion to the 8-bit combinational full adder in the ALU datapath; this block
//   performs the inverse operation where area matters more than latency.
//   Uses a start/busy/done handshake; the result is held until the next operation completes.
//
// PARAMETERS
//   WIDTH   8   operand and result width in bits (>= 2)
//
// PORTS
//   clk     in   1      rising-edge clock
//   rst_n   in   1      synchronous reset, active-low
//   start   in   1      request; sampled only in IDLE or DONE
//   a       in   WIDTH  minuend, captured on the accepting edge
//   b       in   WIDTH  subtrahend, captured on the accepting edge
//   busy    out  1      high while bits are being processed (SHIFT)
//   done    out  1      single-cycle pulse: result registers just updated
//   diff    out  WIDTH  a - b modulo 2^WIDTH
//   bout    out  1      final borrow; 1 iff a < b (unsigned)
//   ovf     out  1      signed overflow: a[MSB]!=b[MSB] && diff[MSB]!=a[MSB]
//   zero    out  1      diff == 0
//
// BEHAVIOUR
//   - Reset (rst_n=0 at a rising edge):
//       state=IDLE; busy, done, diff, bout, ovf, zero all 0; internal shift regs,
//       borrow and counter cleared. Applies mid-operation: the operation is aborted
//       and no done pulse is produced.
//   - FSM:
//       IDLE  -start->  SHIFT
//       SHIFT -(count==WIDTH-1)->  DONE
//       DONE  -start->  SHIFT,  else -> IDLE
//   - Accept: on an edge in IDLE/DONE with start=1:
//       a and b latched into shift regs; borrow=0; count=0.
//   - Start in SHIFT: ignored; the in-flight operation is not disturbed.
//   - SHIFT, each edge, bit i = count:
//       d      = a_i ^ b_i ^ br
//       br_nxt = (~a_i & b_i) | (~(a_i ^ b_i) & br)
//       d shifted into the MSB of the working diff reg; operand regs shift right;
//       count++.
//   - Completion (edge with count==WIDTH-1):
//       diff, bout, ovf, zero load from the final working values; state=DONE.
//   - Latency: accept on edge E -> done=1 after edge E+WIDTH, for exactly one cycle.
//     Back-to-back (start held high): a new operation every WIDTH+1 cycles.
//   - busy = (state==SHIFT); done = (state==DONE); both registered.
//   - diff/bout/ovf/zero change only on completion or reset; stable while busy.
//   - Wrap-around: modulo 2^WIDTH, no saturation. Counter width is clog2(WIDTH).
//
// TESTING
//   1. Reset, then a=0x00 b=0x00 start -> after 8 edges done=1; diff=0x00, bout=0, ovf=0, zero=1.
//   2. a=0x00 b=0x01 -> diff=0xFF, bout=1, ovf=0, zero=0.
//      a=0xFF b=0x00 -> diff=0xFF, bout=0.
//   3. a=0x80 b=0x01 -> diff=0x7F, ovf=1, bout=0.
//      a=0x7F b=0xFF -> diff=0x80, ovf=1, bout=1.
//   4. a=0x37 b=0x12 start; pulse start with a=0xFF b=0xFF while busy
//      -> single done, diff=0x25; outputs held at the previous result until then.
//   5. Reset asserted 3 cycles into an operation -> all outputs 0, no done pulse;
//      the next op (a=0x10 b=0x01) gives diff=0x0F.
//   6. start held high, operand pairs changed each accept -> done every 9 cycles,
//      results correct; compare against a - b for 1000 random pairs.

Source files
------------

// File: rtl/subtrator_serial_if.sv
// Start/busy/done handshake and operand/result bundle
// for the bit-serial subtractor.
interface subtrator_serial_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             zero;

    modport master (
        output start, a, b,
        input  busy, done, diff, bout, ovf, zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, bout, ovf, zero
    );
endinterface

// File: rtl/subtrator_serial.sv
// Bit-serial a - b, LSB first, one full-subtractor cell
// and a registered borrow; result held until the next completion.
module subtrator_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    subtrator_serial_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] wd_q, wd_d;
    logic             bw_q, bw_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic             ai, bi, dbit, bnx;
    logic [WIDTH-1:0] wd_nx;

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        wd_d    = wd_q;
        bw_d    = bw_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        ai    = a_sh_q[0];
        bi    = b_sh_q[0];
        dbit  = ai ^ bi ^ bw_q;
        bnx   = (~ai & bi) | (~(ai ^ bi) & bw_q);
        wd_nx = {dbit, wd_q[WIDTH-1:1]};

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    state_d = SHIFT;
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    wd_d    = '0;
                    bw_d    = 1'b0;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                wd_d   = wd_nx;
                bw_d   = bnx;
                cnt_d  = cnt_q + 1'b1;
                // Last bit: ai/bi are the operand MSBs, dbit the result MSB.
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    diff_d  = wd_nx;
                    bout_d  = bnx;
                    ovf_d   = (ai ^ bi) & (dbit ^ ai);
                    zero_d  = ~|wd_nx;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            wd_q    <= '0;
            bw_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            wd_q    <= wd_d;
            bw_q    <= bw_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.busy = (state_q == SHIFT);
    assign bus.done = (state_q == DONE);
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
    assign bus.ovf  = ovf_q;
    assign bus.zero = zero_q;
endmodule

// File: tb/tb_subtrator_serial.sv
// Scoreboard bench for subtrator_serial: driver pushes expected
// results, a negedge monitor pops them on each done pulse.
module tb_subtrator_serial;
    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        logic         z;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    subtrator_serial_if #(.WIDTH(W)) ifc ();

    subtrator_serial #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    res_t sb_q[$];
    res_t prev;
    int   n_vec = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] av,
                                   input logic [W-1:0] bv);
        res_t r;
        int   ua, ub, sa, sb, sd;
        ua   = int'(av);
        ub   = int'(bv);
        sa   = (ua >= 128) ? ua - 256 : ua;
        sb   = (ub >= 128) ? ub - 256 : ub;
        sd   = sa - sb;
        r.d  = W'((ua - ub + 256) % 256);
        r.bo = (ua < ub);
        r.ov = (sd > 127) || (sd < -128);
        r.z  = (((ua - ub + 256) % 256) == 0);
        return r;
    endfunction

    function automatic res_t outs();
        res_t r;
        r.d  = ifc.diff;
        r.bo = ifc.bout;
        r.ov = ifc.ovf;
        r.z  = ifc.zero;
        return r;
    endfunction

    // Monitor: every done pulse must match the oldest queued result.
    always @(negedge clk) begin
        if (rst_n && ifc.done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                res_t e;
                e = sb_q.pop_front();
                chk("result", 32'(outs()), 32'(e));
            end
        end
    end

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input bit hold, input bit inj);
        res_t e;
        int   lat;
        bit   got;
        e = model(av, bv);
        ifc.a = av;
        ifc.b = bv;
        ifc.start = 1'b1;
        @(posedge clk);
        sb_q.push_back(e);
        n_vec++;
        #1;
        if (!hold) ifc.start = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            if (inj && lat == 3) begin
                ifc.start = 1'b1;
                ifc.a = 8'hFF;
                ifc.b = 8'hFF;
            end
            if (inj && lat == 4) ifc.start = 1'b0;
            @(posedge clk);
            #1;
            lat++;
            if (ifc.done) got = 1'b1;
            else chk("hold", 32'(outs()), 32'(prev));
        end
        if (!got) begin
            chk("timeout", 32'd1, 32'd0);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end else begin
            chk("latency", 32'(lat), 32'(W));
        end
        prev = e;
    endtask

    initial begin
        logic [W-1:0] ta [8];
        logic [W-1:0] tb [8];
        ta = '{8'h00, 8'h00, 8'hFF, 8'h80, 8'h7F, 8'h55, 8'hAA, 8'h01};
        tb = '{8'h00, 8'h01, 8'h00, 8'h01, 8'hFF, 8'h55, 8'h55, 8'h02};
        ifc.start = 1'b0;
        ifc.a = '0;
        ifc.b = '0;
        prev = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(ifc.busy), 32'd0);
        chk("rst_done", 32'(ifc.done), 32'd0);
        chk("rst_outs", 32'(outs()), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_op(ta[i], tb[i], 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("idle_busy", 32'(ifc.busy), 32'd0);

        run_op(8'h37, 8'h12, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("after_inj_idle", 32'(ifc.busy), 32'd0);

        ifc.a = 8'hC3;
        ifc.b = 8'h3C;
        ifc.start = 1'b1;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("busy_mid", 32'(ifc.busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_busy", 32'(ifc.busy), 32'd0);
        chk("abort_done", 32'(ifc.done), 32'd0);
        chk("abort_outs", 32'(outs()), 32'd0);
        rst_n = 1'b1;
        prev = '0;
        repeat (12) @(posedge clk);
        #1;
        chk("abort_idle", 32'(ifc.busy), 32'd0);
        run_op(8'h10, 8'h01, 1'b0, 1'b0);

        for (int i = 0; i < 1000; i++)
            run_op(W'($urandom), W'($urandom), 1'b1, 1'b0);
        ifc.start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
